adc78h90_spi_target: RTL and testbench

Synchronous SPI target that emulates the ADC78H90 8-channel, 12-bit ADC serial interface so that the Penelope ADC driver, or any external SPI master, can read a bank of FPGA-supplied 12-bit values. The block oversamples the master's SCLK, nCS and MOSI on the system clock and decodes the 3-bit channel address from each control word. It returns the addressed channel in the following frame as 4 leading zeros plus 12 data bits, MSB first. It is used for loopback verification of the ADC driver and as a drop-in sensor source on boards without the physical ADC.

---
 rtl/adc78h90_spi_if.sv | 11 +
 rtl/adc78h90_spi_target.sv | 132 +++++++++++++
 tb/tb_adc78h90_spi_target.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/adc78h90_spi_if.sv
// SPI pin bundle between an ADC78H90-style master and the emulated target.
interface adc78h90_spi_if;
    logic SCLK;
    logic nCS;
    logic MOSI;
    logic MISO;
    logic MISO_oe;

    modport master (output SCLK, output nCS, output MOSI, input MISO, input MISO_oe);
    modport slave  (input SCLK, input nCS, input MOSI, output MISO, output MISO_oe);
endinterface

// File: rtl/adc78h90_spi_target.sv
// ADC78H90 serial-interface emulator: oversamples the SPI pins on clock, decodes the
// channel address of each frame and returns that channel's 12-bit value in the next one.
module adc78h90_spi_target #(
    parameter int SYNC_STAGES = 2
) (
    input  logic                clock,
    input  logic                reset,
    adc78h90_spi_if.slave       spi,
    input  logic [95:0]         ain,
    output logic [2:0]          addr,
    output logic                frame_done,
    output logic                frame_abort
);
    localparam int LAST = SYNC_STAGES - 1;

    logic [SYNC_STAGES-1:0] sclk_sync_q, ncs_sync_q, mosi_sync_q;
    logic                   sclk_dly_q, ncs_dly_q;
    logic                   post_rst_q, armed_q;

    logic [11:0] chan [8];
    for (genvar k = 0; k < 8; k++) begin : g_chan
        assign chan[k] = ain[12*k +: 12];
    end

    // armed_q blocks the false nCS fall seen when the chain leaves reset with the pin already low.
    always_ff @(posedge clock) begin
        if (reset) begin
            sclk_sync_q <= '0;
            ncs_sync_q  <= '1;
            mosi_sync_q <= '0;
            sclk_dly_q  <= 1'b0;
            ncs_dly_q   <= 1'b1;
            post_rst_q  <= 1'b0;
            armed_q     <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi.SCLK};
            ncs_sync_q  <= {ncs_sync_q[SYNC_STAGES-2:0], spi.nCS};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi.MOSI};
            sclk_dly_q  <= sclk_sync_q[LAST];
            ncs_dly_q   <= ncs_sync_q[LAST];
            post_rst_q  <= 1'b1;
            if (post_rst_q && ncs_sync_q[0]) armed_q <= 1'b1;
        end
    end

    logic sclk_s, ncs_s, mosi_s;
    logic sclk_rise, sclk_fall, ncs_rise, ncs_fall;

    assign sclk_s    = sclk_sync_q[LAST];
    assign ncs_s     = ncs_sync_q[LAST];
    assign mosi_s    = mosi_sync_q[LAST];
    assign sclk_rise = sclk_s & ~sclk_dly_q;
    assign sclk_fall = ~sclk_s & sclk_dly_q;
    assign ncs_rise  = ncs_s & ~ncs_dly_q;
    assign ncs_fall  = ~ncs_s & ncs_dly_q & armed_q;

    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic        oe_q, oe_d;
    logic [2:0]  addr_q, addr_d;
    logic        done_q, done_d;
    logic        abort_q, abort_d;
    logic [15:0] tx_shift_q, tx_shift_d;
    // Only the last 13 received bits are kept; the address field sits at [12:10] before the final bit.
    logic [12:0] rx_shift_q, rx_shift_d;

    always_comb begin
        bit_cnt_d  = bit_cnt_q;
        oe_d       = oe_q;
        addr_d     = addr_q;
        done_d     = 1'b0;
        abort_d    = 1'b0;
        tx_shift_d = tx_shift_q;
        rx_shift_d = rx_shift_q;
        if (ncs_rise) begin
            oe_d       = 1'b0;
            tx_shift_d = '0;
            bit_cnt_d  = '0;
            abort_d    = (bit_cnt_q != 5'd0) && (bit_cnt_q != 5'd16);
        end else if (ncs_fall) begin
            bit_cnt_d  = '0;
            tx_shift_d = {4'h0, chan[addr_q]};
            oe_d       = 1'b1;
        end else if (oe_q && !ncs_s) begin
            if (sclk_rise) begin
                if (bit_cnt_q != 5'd16) begin
                    rx_shift_d = {rx_shift_q[11:0], mosi_s};
                    bit_cnt_d  = bit_cnt_q + 5'd1;
                    if (bit_cnt_q == 5'd15) begin
                        addr_d = rx_shift_q[12:10];
                        done_d = 1'b1;
                    end
                end
            end else if (sclk_fall) begin
                if (bit_cnt_q == 5'd16) begin
                    bit_cnt_d  = '0;
                    tx_shift_d = {4'h0, chan[addr_q]};
                end else if (bit_cnt_q != 5'd0) begin
                    tx_shift_d = {tx_shift_q[14:0], 1'b0};
                end
            end
        end
    end

    // tx_shift is reset because its bit 15 is the MISO pin itself.
    always_ff @(posedge clock) begin
        if (reset) begin
            bit_cnt_q  <= '0;
            oe_q       <= 1'b0;
            addr_q     <= '0;
            done_q     <= 1'b0;
            abort_q    <= 1'b0;
            tx_shift_q <= '0;
        end else begin
            bit_cnt_q  <= bit_cnt_d;
            oe_q       <= oe_d;
            addr_q     <= addr_d;
            done_q     <= done_d;
            abort_q    <= abort_d;
            tx_shift_q <= tx_shift_d;
        end
    end

    always_ff @(posedge clock) begin
        rx_shift_q <= rx_shift_d;
    end

    assign spi.MISO    = tx_shift_q[15];
    assign spi.MISO_oe = oe_q;
    assign addr        = addr_q;
    assign frame_done  = done_q;
    assign frame_abort = abort_q;
endmodule

// File: tb/tb_adc78h90_spi_target.sv
// Directed bench for adc78h90_spi_target: a slow SPI master driving frames with known answers.
module tb_adc78h90_spi_target;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [95:0] ain   = '0;
    logic [2:0]  addr;
    logic        frame_done, frame_abort;

    adc78h90_spi_if spi ();

    adc78h90_spi_target #(.SYNC_STAGES(2)) dut (
        .clock       (clock),
        .reset       (reset),
        .spi         (spi.slave),
        .ain         (ain),
        .addr        (addr),
        .frame_done  (frame_done),
        .frame_abort (frame_abort)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    int abort_cnt = 0;
    int both_cnt = 0;

    always @(negedge clock) begin
        if (frame_done) done_cnt++;
        if (frame_abort) abort_cnt++;
        if (frame_done && frame_abort) both_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic set_ch(input int k, input logic [11:0] v);
        ain[12*k +: 12] = v;
    endtask

    task automatic xfer_bits(input logic [15:0] mw, input int nb, output logic [15:0] rw);
        rw = '0;
        for (int i = 0; i < nb; i++) begin
            spi.MOSI = mw[15-i];
            cyc(4);
            rw = {rw[14:0], spi.MISO};
            spi.SCLK = 1'b1;
            cyc(4);
            spi.SCLK = 1'b0;
        end
        cyc(4);
    endtask

    task automatic frame(input logic [15:0] mw, output logic [15:0] rw);
        spi.nCS = 1'b0;
        cyc(4);
        xfer_bits(mw, 16, rw);
        spi.nCS = 1'b1;
        cyc(6);
    endtask

    logic [15:0] rw, ra, rb;
    int d0, a0, prev;

    initial begin
        spi.SCLK = 1'b0;
        spi.nCS  = 1'b1;
        spi.MOSI = 1'b0;
        cyc(3);
        chk("rst_miso", 32'(spi.MISO), 0);
        chk("rst_oe", 32'(spi.MISO_oe), 0);
        chk("rst_addr", 32'(addr), 0);
        chk("rst_done", 32'(frame_done), 0);
        chk("rst_abort", 32'(frame_abort), 0);
        reset = 1'b0;
        cyc(4);

        // basic read
        set_ch(0, 12'hABC);
        d0 = done_cnt;
        frame(16'h2000, rw);
        chk("basic_data", 32'(rw), 32'h0ABC);
        chk("basic_addr", 32'(addr), 4);
        chk("basic_done", 32'(done_cnt - d0), 1);
        set_ch(4, 12'h123);
        frame(16'h0000, rw);
        chk("basic_data2", 32'(rw), 32'h0123);
        chk("basic_addr2", 32'(addr), 0);

        // address sweep
        for (int k = 0; k < 8; k++) set_ch(k, 12'(12'h100 + k));
        prev = 0;
        for (int k = 0; k < 8; k++) begin
            frame(16'(k << 11), rw);
            chk($sformatf("sweep_data%0d", k), 32'(rw), 32'(16'h0100 + prev));
            chk($sformatf("sweep_addr%0d", k), 32'(addr), 32'(k));
            prev = k;
        end

        // abort after 9 bits
        d0 = done_cnt;
        a0 = abort_cnt;
        spi.nCS = 1'b0;
        cyc(4);
        xfer_bits(16'h0000, 9, rw);
        spi.nCS = 1'b1;
        cyc(2);
        chk("abort_oe_2cyc", 32'(spi.MISO_oe), 1);
        cyc(1);
        chk("abort_oe_3cyc", 32'(spi.MISO_oe), 0);
        cyc(4);
        chk("abort_pulse", 32'(abort_cnt - a0), 1);
        chk("abort_nodone", 32'(done_cnt - d0), 0);
        chk("abort_addr", 32'(addr), 7);

        // continuous mode: channel 2 then channel 5 with nCS held low
        d0 = done_cnt;
        a0 = abort_cnt;
        spi.nCS = 1'b0;
        cyc(4);
        xfer_bits(16'h1000, 16, ra);
        xfer_bits(16'h2800, 16, rb);
        spi.nCS = 1'b1;
        cyc(6);
        chk("cont_first", 32'(ra), 32'h0107);
        chk("cont_second", 32'(rb), 32'h0102);
        chk("cont_done", 32'(done_cnt - d0), 2);
        chk("cont_addr", 32'(addr), 5);
        chk("cont_noabort", 32'(abort_cnt - a0), 0);

        // snapshot: channel 0 changes at bit 6
        frame(16'h0000, rw);
        chk("snap_pre", 32'(rw), 32'h0105);
        set_ch(0, 12'hFFF);
        spi.nCS = 1'b0;
        cyc(4);
        xfer_bits(16'h0000, 6, ra);
        set_ch(0, 12'h000);
        xfer_bits(16'h0000, 10, rb);
        spi.nCS = 1'b1;
        cyc(6);
        chk("snap_data", 32'({ra[5:0], rb[9:0]}), 32'h0FFF);

        // SCLK rise coincident with nCS fall is dropped
        set_ch(0, 12'h5A5);
        d0 = done_cnt;
        spi.MOSI = 1'b0;
        spi.nCS  = 1'b0;
        spi.SCLK = 1'b1;
        cyc(4);
        spi.SCLK = 1'b0;
        cyc(4);
        xfer_bits(16'h1800, 15, ra);
        chk("prio_15_nodone", 32'(done_cnt - d0), 0);
        xfer_bits(16'h0000, 1, rb);
        chk("prio_16_done", 32'(done_cnt - d0), 1);
        chk("prio_data", 32'({ra[14:0], rb[0]}), 32'h05A5);
        chk("prio_addr", 32'(addr), 3);
        spi.nCS = 1'b1;
        cyc(6);

        // reset at bit 8, nCS left low afterwards
        spi.nCS = 1'b0;
        cyc(4);
        xfer_bits(16'hFFFF, 8, ra);
        reset = 1'b1;
        cyc(2);
        chk("mrst_miso", 32'(spi.MISO), 0);
        chk("mrst_oe", 32'(spi.MISO_oe), 0);
        chk("mrst_addr", 32'(addr), 0);
        reset = 1'b0;
        cyc(2);
        d0 = done_cnt;
        a0 = abort_cnt;
        xfer_bits(16'h3800, 16, ra);
        chk("mrst_nodone", 32'(done_cnt - d0), 0);
        chk("mrst_oe_idle", 32'(spi.MISO_oe), 0);
        chk("mrst_addr_idle", 32'(addr), 0);
        spi.nCS = 1'b1;
        cyc(6);
        chk("mrst_noabort", 32'(abort_cnt - a0), 0);
        frame(16'h0000, rw);
        chk("mrst_recover", 32'(rw), 32'h05A5);

        chk("no_overlap", 32'(both_cnt), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
